// File: rtl/regfile_writeback.sv
// rtl/regfile_writeback.sv - in-order writeback FIFO feeding the register file write port
// Optional WB_FWD_EN adds fwd_data_1..3 (youngest queued data for each read address).
module regfile_writeback #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          alu_valid,
  input  logic [AW-1:0] alu_addr,
  input  logic [DW-1:0] alu_data,
  output logic          alu_ready,
  input  logic          ld_valid,
  input  logic [AW-1:0] ld_addr,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          wb_hold,
  output logic          wb_en,
  output logic [AW-1:0] wb_addr,
  output logic [DW-1:0] wb_data,
  input  logic [AW-1:0] rd_addr_1,
  input  logic [AW-1:0] rd_addr_2,
  input  logic [AW-1:0] rd_addr_3,
  output logic          pend_1,
  output logic          pend_2,
  output logic          pend_3,
`ifdef WB_FWD_EN
  output logic [DW-1:0] fwd_data_1,
  output logic [DW-1:0] fwd_data_2,
  output logic [DW-1:0] fwd_data_3,
`endif
  output logic          full,
  output logic          empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [AW-1:0]    mem_addr [DEPTH];
  logic [DW-1:0]    mem_data [DEPTH];
  logic [DEPTH-1:0] ent_valid;
  logic [DEPTH-1:0] valid_next;
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [PW-1:0]    ld_slot;
  logic [CW-1:0]    count;
  logic [CW-1:0]    free;
  logic             last_ld;
  logic             alu_push;
  logic             ld_push;
  logic             conflict;

  // Only the registered count frees slots; a same-cycle pop never helps a push.
  assign free     = CW'(DEPTH) - count;
  assign conflict = (free == CW'(1)) && alu_valid && ld_valid;

  always_comb begin
    alu_ready = 1'b0;
    ld_ready  = 1'b0;
    if (free >= CW'(2)) begin
      alu_ready = 1'b1;
      ld_ready  = 1'b1;
    end else if (free == CW'(1)) begin
      if (alu_valid && ld_valid) begin
        alu_ready = last_ld;
        ld_ready  = ~last_ld;
      end else begin
        alu_ready = alu_valid;
        ld_ready  = ld_valid;
      end
    end
  end

  assign alu_push = alu_valid & alu_ready;
  assign ld_push  = ld_valid & ld_ready;
  assign ld_slot  = alu_push ? tail + PW'(1) : tail;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign wb_en   = ~empty & ~wb_hold;
  assign wb_addr = empty ? '0 : mem_addr[head];
  assign wb_data = empty ? '0 : mem_data[head];

  always_comb begin
    valid_next = ent_valid;
    if (wb_en)    valid_next[head]    = 1'b0;
    if (alu_push) valid_next[tail]    = 1'b1;
    if (ld_push)  valid_next[ld_slot] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= '0;
      head      <= '0;
      tail      <= '0;
      ent_valid <= '0;
      last_ld   <= 1'b1;
    end else begin
      count     <= count + CW'(alu_push) + CW'(ld_push) - CW'(wb_en);
      head      <= head + PW'(wb_en);
      tail      <= tail + PW'(alu_push) + PW'(ld_push);
      ent_valid <= valid_next;
      if (conflict) last_ld <= ld_push;
    end
  end

  always_ff @(posedge clk) begin
    if (alu_push) begin
      mem_addr[tail] <= alu_addr;
      mem_data[tail] <= alu_data;
    end
    if (ld_push) begin
      mem_addr[ld_slot] <= ld_addr;
      mem_data[ld_slot] <= ld_data;
    end
  end

  function automatic logic pend_of(input logic [AW-1:0] ra);
    logic hit;
    hit = 1'b0;
    for (int i = 0; i < DEPTH; i++)
      if (ent_valid[PW'(i)] && mem_addr[PW'(i)] == ra) hit = 1'b1;
    return hit;
  endfunction

  assign pend_1 = pend_of(rd_addr_1);
  assign pend_2 = pend_of(rd_addr_2);
  assign pend_3 = pend_of(rd_addr_3);

`ifdef WB_FWD_EN
  // Walk oldest to youngest from head so the last hit is the youngest match.
  function automatic logic [DW-1:0] fwd_of(input logic [AW-1:0] ra);
    logic [DW-1:0] val;
    logic [PW-1:0] idx;
    val = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PW'(k);
      if (ent_valid[idx] && mem_addr[idx] == ra) val = mem_data[idx];
    end
    return val;
  endfunction

  assign fwd_data_1 = fwd_of(rd_addr_1);
  assign fwd_data_2 = fwd_of(rd_addr_2);
  assign fwd_data_3 = fwd_of(rd_addr_3);
`endif

endmodule

// File: doc/regfile_writeback.md
Name: regfile_writeback

Overview:
- Write-side companion to the 32x16 three-read/one-write register file.
- Collects results from two producers, ALU and load unit, through valid/ready handshakes.
- Buffers them in an in-order FIFO and drains one write per cycle onto the register file write port (addr/data/enable).
- Reports pending-write hazards for the three read addresses so the issue logic can stall.

Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16.
- AW, 5, register address width (32 registers).
- DW, 16, register data width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU result present
- alu_addr  in  AW  ALU destination register
- alu_data  in  DW  ALU result
- alu_ready  out  1  ALU result accepted this cycle when alu_valid=1
- ld_valid  in  1  load result present
- ld_addr  in  AW  load destination register
- ld_data  in  DW  load data
- ld_ready  out  1  load result accepted this cycle when ld_valid=1
- wb_hold  in  1  suppress draining this cycle
- wb_en  out  1  register file write enable
- wb_addr  out  AW  register file write address
- wb_data  out  DW  register file write data
- rd_addr_1, rd_addr_2, rd_addr_3  in  AW each  issue-stage read addresses
- pend_1, pend_2, pend_3  out  1 each  a queued write targets rd_addr_n
- full  out  1  count==DEPTH
- empty  out  1  count==0

Behaviour:
- Reset is asynchronous on rst_n low. Effects: count=0, head/tail pointers=0, all entry valid bits=0, last_grant=LD (so ALU wins the first conflict).
- Outputs during and after reset: wb_en=0, wb_addr=0, wb_data=0, empty=1, full=0, pend_*=0.
- Storage: DEPTH entries of {addr, data}, written at the tail and read at the head. Pointers wrap modulo DEPTH.
- free = DEPTH-count, computed from the registered count only. A same-cycle pop does not free a slot for that cycle's push.
- Handshake grants:
  - free>=2: alu_ready=1 and ld_ready=1.
  - free==1, only one source valid: that source's ready=1.
  - free==1, both valid: grant the source not in last_grant; last_grant updates to it.
  - free==0: both ready=0.
  - Ready may be 1 while the matching valid=0; no push occurs.
- Push order: when both sources are accepted in the same cycle, the ALU entry is written at tail and the load entry at tail+1. A later entry to the same register therefore overwrites the earlier one in the register file.
- Drain: wb_en=~empty & ~wb_hold, combinational. wb_addr/wb_data come directly from the head entry and read 0 when empty.
- Pop occurs at the clock edge when wb_en=1. The register file always accepts.
- Latency: a result accepted at edge N appears on wb_en in cycle N+1 at the earliest (FIFO empty, no hold).
- Count update per cycle: count_next = count + pushes(0..2) - pop(0..1). Push and pop in the same cycle are legal, including at full (pop only).
- pend_n = OR over valid entries of (entry.addr == rd_addr_n), combinational. Register 0 gets no special treatment.
- Reset mid-operation drops all queued entries; no write is issued for them.

Optional Feature:
- Macro: WB_FWD_EN.
- Defined: adds outputs fwd_data_1, fwd_data_2, fwd_data_3 (DW each).
  - fwd_data_n = data of the youngest valid entry whose addr == rd_addr_n; 0 if there is no match.
  - pend_n keeps its meaning, so issue logic can forward instead of stalling.
- Undefined: the ports and match-select logic are absent. Everything else is identical.

Test Plan:
- Reset with alu_valid=1 held → wb_en=0, empty=1. First accept only after rst_n rises. Write appears the cycle after the accept.
- ALU {3,0x1234} and load {3,0xBEEF} accepted in the same cycle, FIFO empty → cycle+1 wb 3/0x1234, cycle+2 wb 3/0xBEEF. pend_1=1 with rd_addr_1=3 until the second pop.
- wb_hold=1, 4 ALU pushes → full=1, alu_ready=0. Release hold → 4 consecutive writes in push order, then empty=1.
- Count=3 (DEPTH=4), hold=1, both sources valid for 2 cycles → first grant ALU, next cycle no grant (full). After one pop with both valid, grant goes to load.
- Full FIFO, hold=0, both valid → pop occurs, no push that cycle. Next cycle free=1 and one grant is issued.
- WB_FWD_EN defined: queue {7,0x0001} then {7,0x0002} under hold, rd_addr_2=7 → fwd_data_2=0x0002, pend_2=1. rd_addr_2=8 → fwd_data_2=0, pend_2=0.
